// File: rtl/binary_add_arbiter.sv
// ---------------------------------------------------------------------------
// binary_add_arbiter
//
// Shares a single registered adder slice (S <= A+B on a clock edge with en=1,
// S holds otherwise) among NUM_REQ requesters. A round-robin arbiter picks
// one pending request, latches its operands into the adder inputs, pulses the
// adder enable for one cycle and then presents the tagged sum to a consumer
// with valid/ready backpressure. One operation takes at least three cycles:
// IDLE (grant) -> ADD (adder enabled) -> RESP (result held until accepted).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester operand valid
//   req_ready  one-hot grant, asserted combinationally in IDLE only
//   req_a      operand A, requester k at [k*WIDTH +: WIDTH]
//   req_b      operand B, same packing
//   add_a      registered operand A to the adder
//   add_b      registered operand B to the adder
//   add_en     adder enable, high for exactly the ADD cycle
//   add_s      sum from the adder
//   rsp_valid  result valid (RESP state)
//   rsp_ready  consumer accepts the result
//   rsp_id     index of the requester that owns the result
//   rsp_s      sum modulo 2^WIDTH (zero while no result is presented)
//   busy       high whenever an operation is in flight
//   done_cnt   number of accepted responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module binary_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_en,
  input  logic [WIDTH-1:0]         add_s,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_s,
  output logic                     busy,
  output logic [15:0]              done_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  int               best_rank;
  int               rank_k;

  // Round-robin pick: each requester gets a rank equal to its distance past
  // the last winner (last+1 has rank 0). The valid requester with the lowest
  // rank wins, so the most recent winner always ends up with the worst rank.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    best_rank   = NUM_REQ;
    rank_k      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rank_k = (k + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
      if (req_valid[k] && (rank_k < best_rank)) begin
        best_rank   = rank_k;
        grant_found = 1'b1;
        grant_idx   = IDW'(k);
        sel_a       = req_a[k*WIDTH +: WIDTH];
        sel_b       = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // The grant is only offered while idle; it is a pure function of this
  // cycle's valids so a requester that withdraws simply loses the slot.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operation sequencing. Operands and the response tag are captured only on
  // a grant, so add_a/add_b and rsp_id stay put through ADD and RESP and the
  // adder keeps its sum stable for as long as the consumer stalls.
  always_comb begin
    state_d    = state_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_id_d   = rsp_id_q;
    last_d     = last_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          add_a_d  = sel_a;
          add_b_d  = sel_b;
          rsp_id_d = grant_idx;
          last_d   = grant_idx;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any operation in flight and points the
  // round-robin pointer at the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_id_q   <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_id_q   <= rsp_id_d;
      last_q     <= last_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // The adder's own register holds the sum, so the result is passed through
  // rather than copied; it is forced to zero when no response is offered.
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_en    = (state_q == ST_ADD);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_valid ? add_s : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_binary_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_binary_add_arbiter
//
// Drives binary_add_arbiter together with a behavioural registered adder.
// A reference model tracks the operation phase, round-robin pointer, expected
// operands, tag, sum and completion count using plain arithmetic; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_binary_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_en;
  logic [WIDTH-1:0]         add_s;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_s;
  logic                     busy;
  logic [15:0]              done_cnt;

  int checks = 0;
  int errors = 0;

  binary_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s),
    .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder slice: registers A+B when enabled, otherwise holds.
  always @(posedge clk) begin
    if (add_en) add_s <= add_a + add_b;
  end

  // Reference model state
  int          m_phase   = 0;   // 0 idle, 1 adding, 2 responding
  int          m_last    = NUM_REQ - 1;
  int          m_id      = 0;
  int          m_a       = 0;
  int          m_b       = 0;
  int          m_sum     = 0;
  int          m_done    = 0;
  bit          m_started = 1'b0;

  // Captured responses (id and sum at each accepted handshake)
  int id_q[$];
  int sum_q[$];

  // Round-robin rule: search last+1, last+2, ... modulo NUM_REQ.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
  endtask

  task automatic setOperands(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) until the capture queue grows past n0 entries.
  task automatic waitResp(input int n0, input string name);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      if (id_q.size() > n0) return;
    end
    checkOutput({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Single request from one requester: hold valid until granted, then drop.
  task automatic doOp(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n0;
    bit got;
    n0  = id_q.size();
    got = 1'b0;
    setOperands(id, a, b);
    applyStimulus(NUM_REQ'(1) << id, 1'b1);
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) checkOutput("grant_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    applyStimulus('0, 1'b1);
    waitResp(n0, "op");
  endtask

  // Model update on each rising edge from the inputs the DUT also samples.
  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_phase = 0; m_last = NUM_REQ - 1; m_id = 0;
      m_a = 0; m_b = 0; m_done = 0; m_started = 1'b1;
    end else if (m_started) begin
      case (m_phase)
        0: begin
          g = pick(req_valid, m_last);
          if (g >= 0) begin
            m_a     = int'(req_a[g*WIDTH +: WIDTH]);
            m_b     = int'(req_b[g*WIDTH +: WIDTH]);
            m_sum   = (m_a + m_b) % 65536;
            m_id    = g;
            m_last  = g;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (rsp_ready) begin
            m_done  = (m_done + 1) % 65536;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Compare process: every falling edge once the model has seen reset.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    if (m_started) begin
      exp_ready = '0;
      if (m_phase == 0) begin
        g = pick(req_valid, m_last);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(m_phase != 0));
      checkOutput("add_en", 32'(add_en), 32'(m_phase == 1));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
      checkOutput("add_a", 32'(add_a), 32'(m_a));
      checkOutput("add_b", 32'(add_b), 32'(m_b));
      checkOutput("done_cnt", 32'(done_cnt), 32'(m_done));
      if (m_phase == 2) checkOutput("rsp_s", 32'(rsp_s), 32'(m_sum));
      if (rsp_valid && rsp_ready) begin
        id_q.push_back(int'(rsp_id));
        sum_q.push_back(int'(rsp_s));
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    add_s = '0;

    // Reset state, then a lone request from requester 0 is granted at once.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t1_add_en", 32'(add_en), 32'd0);
    checkOutput("t1_add_a", 32'(add_a), 32'd0);
    checkOutput("t1_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t1_rsp_s", 32'(rsp_s), 32'd0);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = id_q.size();
    applyStimulus(4'b0001, 1'b1);
    #1 checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    applyStimulus('0, 1'b1);
    waitResp(n0, "t1");

    // Requester 2 alone: ADD one cycle after the grant, then the response.
    doReset(2);
    setOperands(2, 16'h1234, 16'h0F0F);
    applyStimulus(4'b0100, 1'b1);
    @(posedge clk); #1;
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("t2_add_en", 32'(add_en), 32'd1);
    @(negedge clk);
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t2_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("t2_rsp_s", 32'(rsp_s), 32'h2143);
    @(negedge clk);
    checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);

    // All four requesters pending: grants rotate 0,1,2,3,0.
    doReset(2);
    for (int k = 0; k < NUM_REQ; k++) setOperands(k, 16'(16'h1000 * k + k), 16'(16'h0011 * (k + 1)));
    n0 = id_q.size();
    applyStimulus(4'b1111, 1'b1);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (id_q.size() >= n0 + 5) break;
    end
    applyStimulus('0, 1'b1);
    if (id_q.size() < n0 + 5) begin
      checkOutput("t3_timeout", 32'(id_q.size() - n0), 32'd5);
    end else begin
      checkOutput("t3_order0", 32'(id_q[n0]), 32'd0);
      checkOutput("t3_order1", 32'(id_q[n0 + 1]), 32'd1);
      checkOutput("t3_order2", 32'(id_q[n0 + 2]), 32'd2);
      checkOutput("t3_order3", 32'(id_q[n0 + 3]), 32'd3);
      checkOutput("t3_order4", 32'(id_q[n0 + 4]), 32'd0);
      checkOutput("t3_sum0", 32'(sum_q[n0]), 32'h0011);
      checkOutput("t3_sum3", 32'(sum_q[n0 + 3]), 32'h3047);
    end
    @(negedge clk);
    checkOutput("t3_done_cnt", 32'(done_cnt), 32'd5);

    // Backpressure: response held for five cycles while others wait.
    setOperands(1, 16'h0100, 16'h0023);
    applyStimulus(4'b0010, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      checkOutput("t4_reached_resp", 32'(seen), 32'd1);
    end
    #1 applyStimulus(4'b1111, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4_hold_sum", 32'(rsp_s), 32'h0123);
      checkOutput("t4_hold_id", 32'(rsp_id), 32'd1);
      checkOutput("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    #1 applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd6);

    // Carry out of the top bit is dropped.
    doReset(2);
    doOp(0, 16'hFFFF, 16'h0001);
    checkOutput("t5_wrap1", 32'(sum_q[sum_q.size() - 1]), 32'h0000);
    doOp(3, 16'h8000, 16'h8000);
    checkOutput("t5_wrap2", 32'(sum_q[sum_q.size() - 1]), 32'h0000);
    checkOutput("t5_id", 32'(id_q[id_q.size() - 1]), 32'd3);

    // Reset during ADD aborts the operation and restores requester 0 priority.
    doReset(2);
    setOperands(2, 16'h0001, 16'h0002);
    applyStimulus(4'b0100, 1'b1);
    @(posedge clk); #1;
    checkOutput("t6_in_add", 32'(add_en), 32'd1);
    rst = 1'b1;
    applyStimulus('0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t6_done_cnt", 32'(done_cnt), 32'd0);
    #1;
    n0 = id_q.size();
    applyStimulus(4'b1111, 1'b1);
    #1 checkOutput("t6_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    applyStimulus('0, 1'b1);
    waitResp(n0, "t6");
    if (id_q.size() > n0) checkOutput("t6_rsp_id", 32'(id_q[n0]), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
